axis_output_sink: RTL and testbench

AXIS_OUTPUT_SINK -- requirements
Module: axis_output_sink

---
 rtl/axis_output_sink.sv | 163 ++++++++++++++++
 tb/tb_axis_output_sink.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_output_sink.sv
// AXI-Stream output sink for a kernel monitor.
// Accepts a programmed number of beats under a periodic TREADY throttle,
// accumulates a wrapping checksum and flags TLAST misplacement.
// An idle watchdog aborts a transfer that stops delivering beats.
module axis_output_sink #(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int READY_ON  = 3,
  parameter int READY_OFF = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic              kernel_monitor_clock,
  input  logic              kernel_monitor_reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  expect_beats,
  input  logic [DATA_W-1:0] s_TDATA,
  input  logic              s_TVALID,
  input  logic              s_TLAST,
  output logic              s_TREADY,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              last_err,
  output logic [CNT_W-1:0]  beat_count,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_HOLD   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] READY_ON_C  = CNT_W'(READY_ON);
  localparam logic [CNT_W-1:0] READY_OFF_C = CNT_W'(READY_OFF);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);
  localparam bit               THROTTLE    = (READY_OFF != 0);

  state_t            state;
  logic [CNT_W-1:0]  expect_q;
  logic [CNT_W-1:0]  phase_cnt;
  logic [CNT_W-1:0]  idle_cnt;

  logic              beat_acc;
  logic [CNT_W-1:0]  beat_inc;
  logic              final_beat;
  logic [CNT_W-1:0]  idle_inc;
  logic              idle_expired;
  logic [CNT_W-1:0]  phase_inc;
  logic              on_end;
  logic              off_end;

  // Checksum accumulation keeps only the low DATA_W bits; the carry is dropped.
  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  // Handshake and counter look-ahead shared by the state machine.
  assign beat_acc     = s_TVALID & s_TREADY;
  assign beat_inc     = beat_count + ONE_C;
  assign final_beat   = (beat_inc == expect_q);
  assign idle_inc     = idle_cnt + ONE_C;
  assign idle_expired = (idle_inc == TIMEOUT_C);
  assign phase_inc    = phase_cnt + ONE_C;
  assign on_end       = (phase_inc == READY_ON_C);
  assign off_end      = (phase_inc == READY_OFF_C);

  // Status flags are pure decodes of the registered state.
  assign busy = (state == S_ACCEPT) || (state == S_HOLD);
  assign done = (state == S_DONE);

  // Transfer state machine with registered TREADY, counters and status.
  always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
    if (kernel_monitor_reset) begin
      state      <= S_IDLE;
      s_TREADY   <= 1'b0;
      timeout    <= 1'b0;
      last_err   <= 1'b0;
      beat_count <= '0;
      checksum   <= '0;
      expect_q   <= '0;
      phase_cnt  <= '0;
      idle_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            expect_q   <= expect_beats;
            beat_count <= '0;
            checksum   <= '0;
            timeout    <= 1'b0;
            last_err   <= 1'b0;
            phase_cnt  <= '0;
            idle_cnt   <= '0;
            if (expect_beats == '0) begin
              state    <= S_DONE;
              s_TREADY <= 1'b0;
            end else begin
              state    <= S_ACCEPT;
              s_TREADY <= 1'b1;
            end
          end
        end

        S_ACCEPT: begin
          if (beat_acc) begin
            beat_count <= beat_inc;
            checksum   <= wrap_add(checksum, s_TDATA);
            idle_cnt   <= '0;
            // TLAST must be high exactly on the final beat.
            if (s_TLAST != final_beat) begin
              last_err <= 1'b1;
            end
          end else begin
            idle_cnt <= idle_inc;
          end

          // A final beat outranks watchdog expiry in the same cycle.
          if (beat_acc && final_beat) begin
            state    <= S_DONE;
            s_TREADY <= 1'b0;
          end else if (!beat_acc && idle_expired) begin
            state    <= S_DONE;
            s_TREADY <= 1'b0;
            timeout  <= 1'b1;
          end else if (on_end) begin
            phase_cnt <= '0;
            if (THROTTLE) begin
              state    <= S_HOLD;
              s_TREADY <= 1'b0;
            end
          end else begin
            phase_cnt <= phase_inc;
          end
        end

        S_HOLD: begin
          idle_cnt <= idle_inc;
          if (idle_expired) begin
            state    <= S_DONE;
            s_TREADY <= 1'b0;
            timeout  <= 1'b1;
          end else if (off_end) begin
            state     <= S_ACCEPT;
            s_TREADY  <= 1'b1;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_inc;
          end
        end

        default: begin
          state    <= S_IDLE;
          s_TREADY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_output_sink.sv
// Directed bench for axis_output_sink: cycle-by-cycle vector table plus
// hand-written reset sequences.
module tb_axis_output_sink;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              kernel_monitor_clock = 1'b0;
  logic              kernel_monitor_reset;
  logic              start;
  logic [CNT_W-1:0]  expect_beats;
  logic [DATA_W-1:0] s_TDATA;
  logic              s_TVALID;
  logic              s_TLAST;
  logic              s_TREADY;
  logic              busy;
  logic              done;
  logic              timeout;
  logic              last_err;
  logic [CNT_W-1:0]  beat_count;
  logic [DATA_W-1:0] checksum;

  always #5 kernel_monitor_clock = ~kernel_monitor_clock;

  axis_output_sink #(
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .READY_ON (3),
    .READY_OFF(1),
    .TIMEOUT  (8)
  ) dut (
    .kernel_monitor_clock(kernel_monitor_clock),
    .kernel_monitor_reset(kernel_monitor_reset),
    .start               (start),
    .expect_beats        (expect_beats),
    .s_TDATA             (s_TDATA),
    .s_TVALID            (s_TVALID),
    .s_TLAST             (s_TLAST),
    .s_TREADY            (s_TREADY),
    .busy                (busy),
    .done                (done),
    .timeout             (timeout),
    .last_err            (last_err),
    .beat_count          (beat_count),
    .checksum            (checksum)
  );

  // One clock cycle: inputs applied, then outputs expected after the edge.
  typedef struct {
    logic [31:0] st, eb, tv, td, tl;
    logic [31:0] rdy, bsy, dn, to, le, bc, cs;
  } vec_t;

  vec_t vq[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic add(input logic [31:0] st, input logic [31:0] eb,
                     input logic [31:0] tv, input logic [31:0] td,
                     input logic [31:0] tl, input logic [31:0] rdy,
                     input logic [31:0] bsy, input logic [31:0] dn,
                     input logic [31:0] to, input logic [31:0] le,
                     input logic [31:0] bc, input logic [31:0] cs);
    vec_t v;
    v.st = st; v.eb = eb; v.tv = tv; v.td = td; v.tl = tl;
    v.rdy = rdy; v.bsy = bsy; v.dn = dn; v.to = to; v.le = le;
    v.bc = bc; v.cs = cs;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] rdy,
                            input logic [31:0] bsy, input logic [31:0] dn,
                            input logic [31:0] to, input logic [31:0] le,
                            input logic [31:0] bc, input logic [31:0] cs);
    check($sformatf("%s.tready", tag),     32'(s_TREADY),   rdy);
    check($sformatf("%s.busy", tag),       32'(busy),       bsy);
    check($sformatf("%s.done", tag),       32'(done),       dn);
    check($sformatf("%s.timeout", tag),    32'(timeout),    to);
    check($sformatf("%s.last_err", tag),   32'(last_err),   le);
    check($sformatf("%s.beat_count", tag), 32'(beat_count), bc);
    check($sformatf("%s.checksum", tag),   checksum,        cs);
  endtask

  task automatic drive(input logic st, input logic [CNT_W-1:0] eb,
                       input logic tv, input logic [DATA_W-1:0] td,
                       input logic tl);
    start        = st;
    expect_beats = eb;
    s_TVALID     = tv;
    s_TDATA      = td;
    s_TLAST      = tl;
  endtask

  initial begin
    logic [6:0] rdy_pat;
    rdy_pat = 7'b1011101;

    kernel_monitor_reset = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge kernel_monitor_clock);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0);

    // Released but never started: stays idle even with TVALID high.
    @(negedge kernel_monitor_clock);
    kernel_monitor_reset = 1'b0;
    drive(1'b0, 16'd5, 1'b1, 32'd3, 1'b1);
    repeat (3) @(posedge kernel_monitor_clock);
    #1;
    check_outs("no_start", 0, 0, 0, 0, 0, 0, 0);

    // Four beats under a 3-on/1-off throttle.
    add(1, 4, 0, 0, 0,    1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0,    1, 1, 0, 0, 0, 1, 1);
    add(0, 0, 1, 2, 0,    1, 1, 0, 0, 0, 2, 3);
    add(0, 0, 1, 3, 0,    0, 1, 0, 0, 0, 3, 6);
    add(0, 0, 1, 4, 1,    1, 1, 0, 0, 0, 3, 6);
    add(0, 0, 1, 4, 1,    0, 0, 1, 0, 0, 4, 10);
    add(0, 0, 1, 99, 1,   0, 0, 1, 0, 0, 4, 10);
    // Zero-beat transfer finishes immediately.
    add(1, 0, 0, 0, 0,    0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 5, 1,    0, 0, 1, 0, 0, 0, 0);
    // TLAST early and missing on the final beat.
    add(1, 2, 0, 0, 0,    1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 5, 1,    1, 1, 0, 0, 1, 1, 5);
    add(0, 0, 1, 6, 0,    0, 0, 1, 0, 1, 2, 11);
    // Checksum wrap and ignored starts mid-transfer.
    add(1, 3, 0, 0, 0,             1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 32'hFFFFFFFF, 0,  1, 1, 0, 0, 0, 1, 32'hFFFFFFFF);
    add(1, 1, 1, 32'hFFFFFFFF, 0,  1, 1, 0, 0, 0, 2, 32'hFFFFFFFE);
    add(1, 0, 0, 0, 0,             0, 1, 0, 0, 0, 2, 32'hFFFFFFFE);
    add(0, 0, 1, 7, 1,             1, 1, 0, 0, 0, 2, 32'hFFFFFFFE);
    add(0, 0, 1, 7, 1,             0, 0, 1, 0, 0, 3, 5);
    // Watchdog: one beat then silence until expiry.
    add(1, 3, 0, 0, 0,             1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 32'h1234, 0,      1, 1, 0, 0, 0, 1, 32'h1234);
    for (int k = 0; k < 7; k++)
      add(0, 0, 0, 32'hDEAD, 1, 32'(rdy_pat[6-k]), 1, 0, 0, 0, 1, 32'h1234);
    add(0, 0, 0, 0, 0,             0, 0, 1, 1, 0, 1, 32'h1234);
    // Final beat on the cycle the watchdog would expire.
    add(1, 2, 0, 0, 0,             1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 10, 0,            1, 1, 0, 0, 0, 1, 10);
    for (int k = 0; k < 7; k++)
      add(0, 0, 0, 0, 0, 32'(rdy_pat[6-k]), 1, 0, 0, 0, 1, 10);
    add(0, 0, 1, 20, 1,            0, 0, 1, 0, 0, 2, 30);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge kernel_monitor_clock);
      drive(vq[i].st[0], vq[i].eb[CNT_W-1:0], vq[i].tv[0], vq[i].td, vq[i].tl[0]);
      @(posedge kernel_monitor_clock);
      #1;
      check_outs($sformatf("v%0d", i), vq[i].rdy, vq[i].bsy, vq[i].dn,
                 vq[i].to, vq[i].le, vq[i].bc, vq[i].cs);
    end

    // Reset mid-transfer after two beats clears everything without a clock.
    @(negedge kernel_monitor_clock);
    drive(1'b1, 16'd4, 1'b0, '0, 1'b0);
    @(posedge kernel_monitor_clock);
    #1;
    check("mid.busy", 32'(busy), 1);
    @(negedge kernel_monitor_clock);
    drive(1'b0, '0, 1'b1, 32'h11, 1'b1);
    @(posedge kernel_monitor_clock);
    @(negedge kernel_monitor_clock);
    drive(1'b0, '0, 1'b1, 32'h22, 1'b0);
    @(posedge kernel_monitor_clock);
    #1;
    check_outs("mid", 1, 1, 0, 0, 1, 2, 32'h33);
    @(negedge kernel_monitor_clock);
    #2;
    kernel_monitor_reset = 1'b1;
    #1;
    check_outs("async_rst", 0, 0, 0, 0, 0, 0, 0);
    #1;
    kernel_monitor_reset = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    @(posedge kernel_monitor_clock);
    #1;
    check_outs("post_rst", 0, 0, 0, 0, 0, 0, 0);

    // Clean one-beat transfer after reset.
    @(negedge kernel_monitor_clock);
    drive(1'b1, 16'd1, 1'b0, '0, 1'b0);
    @(posedge kernel_monitor_clock);
    #1;
    check_outs("clean_start", 1, 1, 0, 0, 0, 0, 0);
    @(negedge kernel_monitor_clock);
    drive(1'b0, '0, 1'b1, 32'h55, 1'b1);
    @(posedge kernel_monitor_clock);
    #1;
    check_outs("clean_done", 0, 0, 1, 0, 0, 1, 32'h55);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
